// File: rtl/mfp_ahb_pkg.sv
// Shared AHB-lite encodings, default-slave FSM states and the board memory map
// used to build the interconnect's match/mask tables.
package mfp_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] DS_IDLE = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;

    localparam logic [31:0] MAP_BOOT_MATCH = 32'hBFC0_0000;
    localparam logic [31:0] MAP_BOOT_MASK  = 32'hFFC0_0000;
    localparam logic [31:0] MAP_RAM_MATCH  = 32'h8000_0000;
    localparam logic [31:0] MAP_RAM_MASK   = 32'hF000_0000;
    localparam logic [31:0] MAP_GPIO_MATCH = 32'hBF80_0000;
    localparam logic [31:0] MAP_GPIO_MASK  = 32'hFFC0_0000;

    // Slave 0 sits in the low 32 bits of the packed tables.
    localparam logic [95:0] MAP3_MATCH = {MAP_GPIO_MATCH, MAP_RAM_MATCH, MAP_BOOT_MATCH};
    localparam logic [95:0] MAP3_MASK  = {MAP_GPIO_MASK,  MAP_RAM_MASK,  MAP_BOOT_MASK};

    function automatic logic is_xfer(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/mfp_ahb_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ accesses with a two-cycle ERROR
// and logs the address/direction of the latest one plus a saturating count.
module mfp_ahb_default_slave
    import mfp_ahb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hit,
    input  logic        i_hready,
    input  logic [31:0] i_haddr,
    input  logic        i_hwrite,
    output logic        o_hready,
    output logic        o_hresp,
    output logic [31:0] o_err_addr,
    output logic [15:0] o_err_cnt,
    output logic        o_err_write
);

    logic [1:0]  r_state;
    logic [31:0] r_err_addr;
    logic [15:0] r_err_cnt;
    logic        r_err_write;
    logic        w_accept;

    assign w_accept = i_hit & i_hready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= DS_IDLE;
            r_err_addr  <= '0;
            r_err_cnt   <= '0;
            r_err_write <= 1'b0;
        end else begin
            case (r_state)
                DS_IDLE: if (w_accept) r_state <= DS_ERR1;
                DS_ERR1: r_state <= DS_ERR2;
                DS_ERR2: r_state <= w_accept ? DS_ERR1 : DS_IDLE;
                default: r_state <= DS_IDLE;
            endcase
            if (w_accept) begin
                r_err_addr  <= i_haddr;
                r_err_write <= i_hwrite;
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign o_hready    = (r_state != DS_ERR1);
    assign o_hresp     = (r_state != DS_IDLE) ? HRESP_ERROR : HRESP_OKAY;
    assign o_err_addr  = r_err_addr;
    assign o_err_cnt   = r_err_cnt;
    assign o_err_write = r_err_write;

endmodule

// File: rtl/mfp_ahb_xbar.sv
// Single-master AHB-lite interconnect: table-driven address decode, data-phase
// select register that only advances on HREADY, and a built-in default slave.
module mfp_ahb_xbar
    import mfp_ahb_pkg::*;
#(
    parameter int                        N_SLAVES   = 5,
    parameter logic [N_SLAVES*32-1:0]    ADDR_MATCH = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0]    ADDR_MASK  = {N_SLAVES{32'h0}},
    parameter int                        DATA_W     = 32
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [N_SLAVES-1:0]          S_HSEL,
    input  logic [N_SLAVES-1:0]          S_HREADYOUT,
    input  logic [N_SLAVES-1:0]          S_HRESP,
    input  logic [N_SLAVES*DATA_W-1:0]   S_HRDATA,
    output logic [31:0]                  ERR_ADDR,
    output logic [15:0]                  ERR_CNT,
    output logic                         ERR_WRITE
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    logic [N_SLAVES-1:0] w_hit;
    logic [N_SLAVES-1:0] w_hsel;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_any;
    logic                w_xfer;
    logic                w_dflt_hit;
    logic                w_ds_hready;
    logic                w_ds_hresp;
    logic [DATA_W-1:0]   w_rdata [N_SLAVES];

    logic [IDX_W-1:0]    r_dsel_idx;
    logic                r_dsel_vld;
    logic                r_dsel_dflt;

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_slv
        assign w_hit[i]   = (HADDR & ADDR_MASK[32*i +: 32]) == ADDR_MATCH[32*i +: 32];
        assign w_rdata[i] = S_HRDATA[DATA_W*i +: DATA_W];
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        w_hsel    = '0;
        w_sel_idx = '0;
        w_any     = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hsel    = '0;
                w_hsel[i] = 1'b1;
                w_sel_idx = i[IDX_W-1:0];
                w_any     = 1'b1;
            end
        end
    end

    assign S_HSEL     = w_hsel;
    assign w_xfer     = is_xfer(HTRANS);
    assign w_dflt_hit = w_xfer & ~w_any;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dsel_idx  <= '0;
            r_dsel_vld  <= 1'b0;
            r_dsel_dflt <= 1'b0;
        end else if (HREADY) begin
            r_dsel_idx  <= w_sel_idx;
            r_dsel_vld  <= w_xfer;
            r_dsel_dflt <= ~w_any;
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = '0;
        if (r_dsel_vld) begin
            if (r_dsel_dflt) begin
                HREADY = w_ds_hready;
                HRESP  = w_ds_hresp;
            end else begin
                HREADY = S_HREADYOUT[r_dsel_idx];
                HRESP  = S_HRESP[r_dsel_idx];
                HRDATA = w_rdata[r_dsel_idx];
            end
        end
    end

    mfp_ahb_default_slave u_default_slave (
        .i_clk       (HCLK),
        .i_rst       (HRESET),
        .i_hit       (w_dflt_hit),
        .i_hready    (HREADY),
        .i_haddr     (HADDR),
        .i_hwrite    (HWRITE),
        .o_hready    (w_ds_hready),
        .o_hresp     (w_ds_hresp),
        .o_err_addr  (ERR_ADDR),
        .o_err_cnt   (ERR_CNT),
        .o_err_write (ERR_WRITE)
    );

endmodule

// File: tb/tb_mfp_ahb_xbar.sv
// Directed cycle-table bench for mfp_ahb_xbar on a three-slave map, plus
// reset-abort, counter-saturation and overlapping-map priority sequences.
module tb_mfp_ahb_xbar;
    import mfp_ahb_pkg::*;

    localparam logic [31:0] D0 = 32'hAAAA_0000;
    localparam logic [31:0] D1 = 32'hBBBB_1111;
    localparam logic [31:0] D2 = 32'hCCCC_2222;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hrdata;
    logic        hready, hresp;
    logic [2:0]  s_hsel;
    logic [2:0]  s_hreadyout, s_hresp;
    logic [95:0] s_hrdata;
    logic [31:0] err_addr;
    logic [15:0] err_cnt;
    logic        err_write;

    logic [31:0] ov_haddr;
    logic [31:0] ov_hrdata;
    logic        ov_hready, ov_hresp;
    logic [2:0]  ov_hsel;
    logic [31:0] ov_err_addr;
    logic [15:0] ov_err_cnt;
    logic        ov_err_write;
    logic [1:0]  ov_htrans;
    logic        ov_hwrite;

    int n_chk = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    mfp_ahb_xbar #(.N_SLAVES(3), .ADDR_MATCH(MAP3_MATCH), .ADDR_MASK(MAP3_MASK), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .S_HSEL(s_hsel),
        .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp), .S_HRDATA(s_hrdata),
        .ERR_ADDR(err_addr), .ERR_CNT(err_cnt), .ERR_WRITE(err_write)
    );

    // Slave 0 and slave 1 both cover 0x80000000; slave 0 is narrower.
    mfp_ahb_xbar #(.N_SLAVES(3),
                   .ADDR_MATCH({32'hBF80_0000, 32'h8000_0000, 32'h8000_0000}),
                   .ADDR_MASK ({32'hFFC0_0000, 32'hF000_0000, 32'hFFF0_0000}),
                   .DATA_W(32)) u_ovl (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(ov_haddr), .HTRANS(ov_htrans), .HWRITE(ov_hwrite),
        .HRDATA(ov_hrdata), .HREADY(ov_hready), .HRESP(ov_hresp), .S_HSEL(ov_hsel),
        .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp), .S_HRDATA(s_hrdata),
        .ERR_ADDR(ov_err_addr), .ERR_CNT(ov_err_cnt), .ERR_WRITE(ov_err_write)
    );

    typedef struct {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  rdy;
        logic [2:0]  resp;
        logic [2:0]  hsel;
        logic        hready;
        logic        hresp;
        logic [31:0] rdata;
        logic [15:0] cnt;
        logic [31:0] eaddr;
        logic        ewr;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [1:0] t, input logic w,
                       input logic [2:0] rdy, input logic [2:0] rsp, input logic [2:0] sel,
                       input logic rd, input logic rs, input logic [31:0] dat,
                       input logic [15:0] cnt, input logic [31:0] ea, input logic ew);
        vec_t v;
        v.haddr = a; v.htrans = t; v.hwrite = w; v.rdy = rdy; v.resp = rsp;
        v.hsel = sel; v.hready = rd; v.hresp = rs; v.rdata = dat;
        v.cnt = cnt; v.eaddr = ea; v.ewr = ew;
        vq.push_back(v);
    endtask

    task automatic unmapped_access();
        @(negedge HCLK);
        haddr = 32'h4000_0000; htrans = HTRANS_NONSEQ; hwrite = 1'b0;
        @(negedge HCLK);
        htrans = HTRANS_IDLE;
        @(negedge HCLK);
        @(negedge HCLK);
    endtask

    initial begin
        HRESET = 1'b1;
        haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        s_hreadyout = 3'b111; s_hresp = 3'b000;
        s_hrdata = {D2, D1, D0};
        ov_haddr = '0; ov_htrans = HTRANS_IDLE; ov_hwrite = 1'b0;

        //   haddr          htrans          w  rdy     resp    hsel    rd rs rdata cnt   eaddr         ew
        add(32'hBFC0_0010, HTRANS_NONSEQ, 0, 3'b111, 3'b000, 3'b001, 1, 0, '0, 16'd0, 32'h0, 0);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b000, 3'b000, 1, 0, D0, 16'd0, 32'h0, 0);
        add(32'h8000_0004, HTRANS_NONSEQ, 0, 3'b111, 3'b000, 3'b010, 1, 0, '0, 16'd0, 32'h0, 0);
        add(32'hBF80_0000, HTRANS_NONSEQ, 0, 3'b101, 3'b000, 3'b100, 0, 0, D1, 16'd0, 32'h0, 0);
        add(32'hBF80_0000, HTRANS_NONSEQ, 0, 3'b101, 3'b000, 3'b100, 0, 0, D1, 16'd0, 32'h0, 0);
        add(32'hBF80_0000, HTRANS_NONSEQ, 0, 3'b101, 3'b000, 3'b100, 0, 0, D1, 16'd0, 32'h0, 0);
        add(32'hBF80_0000, HTRANS_NONSEQ, 0, 3'b111, 3'b000, 3'b100, 1, 0, D1, 16'd0, 32'h0, 0);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b000, 3'b000, 1, 0, D2, 16'd0, 32'h0, 0);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b000, 3'b000, 1, 0, '0, 16'd0, 32'h0, 0);
        add(32'h8000_0008, HTRANS_NONSEQ, 0, 3'b111, 3'b000, 3'b010, 1, 0, '0, 16'd0, 32'h0, 0);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b101, 3'b010, 3'b000, 0, 1, D1, 16'd0, 32'h0, 0);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b010, 3'b000, 1, 1, D1, 16'd0, 32'h0, 0);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b000, 3'b000, 1, 0, '0, 16'd0, 32'h0, 0);
        add(32'h4000_0000, HTRANS_IDLE,   1, 3'b111, 3'b000, 3'b000, 1, 0, '0, 16'd0, 32'h0, 0);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b000, 3'b000, 1, 0, '0, 16'd0, 32'h0, 0);
        add(32'h4000_0000, HTRANS_NONSEQ, 1, 3'b111, 3'b000, 3'b000, 1, 0, '0, 16'd0, 32'h0, 0);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b000, 3'b000, 0, 1, '0, 16'd1, 32'h4000_0000, 1);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b000, 3'b000, 1, 1, '0, 16'd1, 32'h4000_0000, 1);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b000, 3'b000, 1, 0, '0, 16'd1, 32'h4000_0000, 1);
        add(32'h5000_0000, HTRANS_SEQ,    0, 3'b111, 3'b000, 3'b000, 1, 0, '0, 16'd1, 32'h4000_0000, 1);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b000, 3'b000, 0, 1, '0, 16'd2, 32'h5000_0000, 0);
        add(32'h6000_0000, HTRANS_NONSEQ, 0, 3'b111, 3'b000, 3'b000, 1, 1, '0, 16'd2, 32'h5000_0000, 0);
        add(32'hBFC0_0000, HTRANS_NONSEQ, 0, 3'b111, 3'b000, 3'b001, 0, 1, '0, 16'd3, 32'h6000_0000, 0);
        add(32'hBFC0_0000, HTRANS_NONSEQ, 0, 3'b111, 3'b000, 3'b001, 1, 1, '0, 16'd3, 32'h6000_0000, 0);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b000, 3'b000, 1, 0, D0, 16'd3, 32'h6000_0000, 0);
        add(32'h4000_0000, HTRANS_BUSY,   0, 3'b111, 3'b000, 3'b000, 1, 0, '0, 16'd3, 32'h6000_0000, 0);
        add(32'h0000_0000, HTRANS_IDLE,   0, 3'b111, 3'b000, 3'b000, 1, 0, '0, 16'd3, 32'h6000_0000, 0);

        repeat (2) @(negedge HCLK);
        #1;
        chk("rst_hready", 32'(hready), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_err_write", 32'(err_write), 32'd0);
        HRESET = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge HCLK);
            haddr = vq[i].haddr; htrans = vq[i].htrans; hwrite = vq[i].hwrite;
            s_hreadyout = vq[i].rdy; s_hresp = vq[i].resp;
            #1;
            chk($sformatf("row%0d_hsel", i), 32'(s_hsel), 32'(vq[i].hsel));
            chk($sformatf("row%0d_hready", i), 32'(hready), 32'(vq[i].hready));
            chk($sformatf("row%0d_hresp", i), 32'(hresp), 32'(vq[i].hresp));
            chk($sformatf("row%0d_hrdata", i), hrdata, vq[i].rdata);
            chk($sformatf("row%0d_err_cnt", i), 32'(err_cnt), 32'(vq[i].cnt));
            chk($sformatf("row%0d_err_addr", i), err_addr, vq[i].eaddr);
            chk($sformatf("row%0d_err_write", i), 32'(err_write), 32'(vq[i].ewr));
        end

        // Reset while the default slave sits in ERR1.
        @(negedge HCLK);
        haddr = 32'h4000_0000; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
        s_hreadyout = 3'b111; s_hresp = 3'b000;
        @(negedge HCLK);
        htrans = HTRANS_IDLE; hwrite = 1'b0;
        #1;
        chk("err1_pre_rst_hready", 32'(hready), 32'd0);
        chk("err1_pre_rst_cnt", 32'(err_cnt), 32'd4);
        HRESET = 1'b1;
        @(negedge HCLK);
        #1;
        chk("err1_rst_hready", 32'(hready), 32'd1);
        chk("err1_rst_hresp", 32'(hresp), 32'd0);
        chk("err1_rst_cnt", 32'(err_cnt), 32'd0);
        chk("err1_rst_addr", err_addr, 32'd0);
        HRESET = 1'b0;

        // Reset during a slave wait state drops the data phase.
        @(negedge HCLK);
        haddr = 32'h8000_0000; htrans = HTRANS_NONSEQ;
        @(negedge HCLK);
        htrans = HTRANS_IDLE; s_hreadyout = 3'b101;
        #1;
        chk("wait_pre_rst_hready", 32'(hready), 32'd0);
        HRESET = 1'b1;
        @(negedge HCLK);
        #1;
        chk("wait_rst_hready", 32'(hready), 32'd1);
        chk("wait_rst_hrdata", hrdata, 32'd0);
        HRESET = 1'b0;
        s_hreadyout = 3'b111;

        // Counter saturation.
        @(negedge HCLK);
        #1;
        force dut.u_default_slave.r_err_cnt = 16'hFFFE;
        #1;
        release dut.u_default_slave.r_err_cnt;
        unmapped_access();
        #1;
        chk("sat_cnt_first", 32'(err_cnt), 32'h0000_FFFF);
        unmapped_access();
        #1;
        chk("sat_cnt_hold", 32'(err_cnt), 32'h0000_FFFF);
        chk("sat_err_addr", err_addr, 32'h4000_0000);

        // Lowest index wins on overlapping entries.
        ov_haddr = 32'h8000_0000; #1;
        chk("ovl_both_hit", 32'(ov_hsel), 32'd1);
        ov_haddr = 32'h8010_0000; #1;
        chk("ovl_only_s1", 32'(ov_hsel), 32'd2);
        ov_haddr = 32'hBF80_0004; #1;
        chk("ovl_s2", 32'(ov_hsel), 32'd4);
        ov_haddr = 32'h4000_0000; #1;
        chk("ovl_none", 32'(ov_hsel), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
